// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icode/status constants and pipeline control state type.
package y86_pkg;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {RUN, WAIT_MEM, HALTED} state_e;

    function automatic logic is_exc(input logic [3:0] s);
        return s inside {S_HLT, S_ADR, S_INS};
    endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load/use, ret, mispredict and memory-op terms.
module hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] d_icode_i,
    input  logic [3:0] e_icode_i,
    input  logic [3:0] m_icode_i,
    input  logic [3:0] d_src_a_i,
    input  logic [3:0] d_src_b_i,
    input  logic [3:0] e_dst_m_i,
    input  logic       e_cnd_i,
    output logic       load_use_o,
    output logic       ret_in_o,
    output logic       mispred_o,
    output logic       memop_o
);
    always_comb begin
        memop_o    = m_icode_i inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
        load_use_o = (e_icode_i inside {I_MRMOVQ, I_POPQ}) && e_dst_m_i != REG_NONE &&
                     (e_dst_m_i == d_src_a_i || e_dst_m_i == d_src_b_i);
        ret_in_o   = d_icode_i == I_RET || e_icode_i == I_RET || m_icode_i == I_RET;
        mispred_o  = e_icode_i == I_JXX && !e_cnd_i;
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage stall/bubble control with memory-wait freeze and halt parking.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    input  logic             dmem_ready,
    output logic             F_stall,
    output logic             D_stall,
    output logic             E_stall,
    output logic             M_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_bubble,
    output logic             set_cc,
    output logic             dmem_req,
    output logic             mem_err,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TO_LAST = WW'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic load_use, ret_in, mispred, memop;
    logic m_exc, w_exc, start_wait, to_hit, act, wt, hl, rn;

    hazard_detect u_hazard (
        .d_icode_i (D_icode),
        .e_icode_i (E_icode),
        .m_icode_i (M_icode),
        .d_src_a_i (d_srcA),
        .d_src_b_i (d_srcB),
        .e_dst_m_i (E_dstM),
        .e_cnd_i   (e_cnd),
        .load_use_o(load_use),
        .ret_in_o  (ret_in),
        .mispred_o (mispred),
        .memop_o   (memop)
    );

    always_comb begin
        m_exc      = is_exc(m_stat);
        w_exc      = is_exc(W_stat);
        start_wait = memop && m_stat == S_AOK && !dmem_ready;
        to_hit     = wait_q == TO_LAST;
        act        = !reset;
        // wt: frozen for memory, either already waiting or stalling on the first miss cycle
        wt         = act && (state_q == WAIT_MEM || (state_q == RUN && start_wait));
        hl         = act && state_q == HALTED;
        rn         = act && state_q == RUN && !wt;
        F_stall    = hl || wt || (rn && (load_use || ret_in));
        D_stall    = hl || wt || (rn && load_use);
        E_stall    = hl || wt;
        M_stall    = hl || wt;
        W_stall    = hl || (rn && w_exc);
        D_bubble   = reset || (rn && (mispred || (ret_in && !load_use)));
        E_bubble   = reset || (rn && (mispred || load_use));
        M_bubble   = reset || (rn && (m_exc || w_exc));
        W_bubble   = reset || wt;
        set_cc     = rn && E_icode == I_OPQ && !m_exc && !w_exc;
        dmem_req   = act && memop && m_stat == S_AOK && state_q != HALTED;
        mem_err    = act && state_q == WAIT_MEM && to_hit && !dmem_ready;
        halted     = hl;
        stall_cnt  = stall_cnt_q;
        state_d    = (state_q == HALTED || w_exc) ? HALTED :
                     state_q == RUN ? (start_wait ? WAIT_MEM : RUN) :
                     (dmem_ready || to_hit) ? RUN : WAIT_MEM;
        wait_d     = state_q == WAIT_MEM ? wait_q + 1'b1 : '0;
        stall_cnt_d = (F_stall && !hl && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenario checks of pipe_ctrl hazard, wait, timeout and halt behaviour.
module tb_pipe_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    logic [3:0] D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, m_stat, W_stat;
    logic e_cnd, dmem_ready;
    logic F_stall, D_stall, E_stall, M_stall, W_stall;
    logic D_bubble, E_bubble, M_bubble, W_bubble, set_cc, dmem_req, mem_err, halted;
    logic [31:0] stall_cnt;
    logic [12:0] ctl;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd), .m_stat(m_stat),
        .W_stat(W_stat), .dmem_ready(dmem_ready), .F_stall(F_stall), .D_stall(D_stall),
        .E_stall(E_stall), .M_stall(M_stall), .W_stall(W_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_bubble(W_bubble), .set_cc(set_cc),
        .dmem_req(dmem_req), .mem_err(mem_err), .halted(halted), .stall_cnt(stall_cnt)
    );

    // ctl = {F,D,E,M,W stall | D,E,M,W bubble | set_cc, dmem_req, mem_err, halted}
    assign ctl = {F_stall, D_stall, E_stall, M_stall, W_stall,
                  D_bubble, E_bubble, M_bubble, W_bubble, set_cc, dmem_req, mem_err, halted};

    task automatic idle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
        e_cnd = 1'b1; m_stat = 4'h1; W_stat = 4'h1; dmem_ready = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        E_icode = 4'h6;
        reset = 1'b1;
        step();
        n_cmp++; if (ctl !== 13'b00000_1111_0000) begin n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl, 13'b00000_1111_0000); end
        n_cmp++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        reset = 1'b0;
        #1;
        n_cmp++; if (ctl !== 13'b00000_0000_1000) begin n_bad++; $display("FAIL run_opq: got %b want %b", ctl, 13'b00000_0000_1000); end
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        n_cmp++; if (ctl !== 13'b11000_0100_0000) begin n_bad++; $display("FAIL load_use: got %b want %b", ctl, 13'b11000_0100_0000); end
        step();
        idle();
        #1;
        n_cmp++; if (ctl !== 13'b00000_0000_0000) begin n_bad++; $display("FAIL load_use_clear: got %b want %b", ctl, 13'b0); end
        n_cmp++; if (stall_cnt !== 32'd1) begin n_bad++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt); end
        E_icode = 4'hB; E_dstM = 4'hF; d_srcA = 4'hF;
        #1;
        n_cmp++; if (ctl !== 13'b00000_0000_0000) begin n_bad++; $display("FAIL reg_none: got %b want %b", ctl, 13'b0); end
        step();
    endtask

    task automatic test_mispred();
        idle();
        E_icode = 4'h7; e_cnd = 1'b0;
        #1;
        n_cmp++; if (ctl !== 13'b00000_1100_0000) begin n_bad++; $display("FAIL mispred: got %b want %b", ctl, 13'b00000_1100_0000); end
        e_cnd = 1'b1;
        #1;
        n_cmp++; if (ctl !== 13'b00000_0000_0000) begin n_bad++; $display("FAIL taken_jmp: got %b want %b", ctl, 13'b0); end
        step();
    endtask

    task automatic test_ret_load_use();
        idle();
        D_icode = 4'h9;
        #1;
        n_cmp++; if (ctl !== 13'b10000_1000_0000) begin n_bad++; $display("FAIL ret: got %b want %b", ctl, 13'b10000_1000_0000); end
        E_icode = 4'h5; E_dstM = 4'h2; d_srcB = 4'h2;
        #1;
        n_cmp++; if (ctl !== 13'b11000_0100_0000) begin n_bad++; $display("FAIL ret_load_use: got %b want %b", ctl, 13'b11000_0100_0000); end
        step();
    endtask

    task automatic test_mem_wait();
        do_reset();
        M_icode = 4'h5; dmem_ready = 1'b0; E_icode = 4'h7; e_cnd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) dmem_ready = 1'b1;
            #1;
            n_cmp++; if (ctl !== 13'b11110_0001_0100) begin n_bad++; $display("FAIL mem_wait_%0d: got %b want %b", i, ctl, 13'b11110_0001_0100); end
            step();
        end
        n_cmp++; if (ctl !== 13'b00000_1100_0100) begin n_bad++; $display("FAIL mem_resume: got %b want %b", ctl, 13'b00000_1100_0100); end
        n_cmp++; if (stall_cnt !== 32'd3) begin n_bad++; $display("FAIL mem_cnt: got %0d want 3", stall_cnt); end
        idle();
        M_icode = 4'h4;
        #1;
        n_cmp++; if (ctl !== 13'b00000_0000_0100) begin n_bad++; $display("FAIL zero_lat: got %b want %b", ctl, 13'b00000_0000_0100); end
        step();
    endtask

    task automatic test_timeout();
        logic [12:0] exp;
        do_reset();
        M_icode = 4'h5; dmem_ready = 1'b0;
        #1;
        n_cmp++; if (ctl !== 13'b11110_0001_0100) begin n_bad++; $display("FAIL to_first: got %b want %b", ctl, 13'b11110_0001_0100); end
        for (int i = 0; i < 4; i++) begin
            step();
            exp = (i == 3) ? 13'b11110_0001_0110 : 13'b11110_0001_0100;
            n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL to_wait_%0d: got %b want %b", i, ctl, exp); end
        end
        idle();
        step();
        n_cmp++; if (ctl !== 13'b00000_0000_0000) begin n_bad++; $display("FAIL to_run: got %b want %b", ctl, 13'b0); end
        n_cmp++; if (stall_cnt !== 32'd5) begin n_bad++; $display("FAIL to_cnt: got %0d want 5", stall_cnt); end
        M_icode = 4'h5; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        dmem_ready = 1'b1;
        #1;
        n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL ready_beats_to: got %b want 0", mem_err); end
        idle();
        step();
        n_cmp++; if (ctl !== 13'b00000_0000_0000) begin n_bad++; $display("FAIL ready_to_run: got %b want %b", ctl, 13'b0); end
    endtask

    task automatic test_halt();
        do_reset();
        W_stat = 4'h2;
        #1;
        n_cmp++; if (ctl !== 13'b00001_0010_0000) begin n_bad++; $display("FAIL halt_entry: got %b want %b", ctl, 13'b00001_0010_0000); end
        step();
        idle();
        M_icode = 4'h5; D_icode = 4'h9;
        #1;
        n_cmp++; if (ctl !== 13'b11111_0000_0001) begin n_bad++; $display("FAIL halted: got %b want %b", ctl, 13'b11111_0000_0001); end
        step();
        step();
        n_cmp++; if (ctl !== 13'b11111_0000_0001) begin n_bad++; $display("FAIL halt_stays: got %b want %b", ctl, 13'b11111_0000_0001); end
        n_cmp++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL halt_cnt: got %0d want 0", stall_cnt); end
        reset = 1'b1;
        #1;
        n_cmp++; if (ctl !== 13'b00000_1111_0000) begin n_bad++; $display("FAIL halt_flush: got %b want %b", ctl, 13'b00000_1111_0000); end
        step();
        reset = 1'b0;
        idle();
        #1;
        n_cmp++; if (ctl !== 13'b00000_0000_0000) begin n_bad++; $display("FAIL halt_reset_run: got %b want %b", ctl, 13'b0); end
        step();
    endtask

    task automatic test_halt_in_wait();
        do_reset();
        M_icode = 4'h5; dmem_ready = 1'b0;
        step();
        W_stat = 4'h3;
        step();
        W_stat = 4'h1;
        #1;
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL wait_to_halt: got %b want 1", halted); end
        do_reset();
        M_icode = 4'h5; dmem_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        #1;
        n_cmp++; if (ctl !== 13'b00000_0000_0000 || stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_mid_wait: got %b cnt %0d want %b cnt 0", ctl, stall_cnt, 13'b0); end
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_mispred();
        test_ret_load_use();
        test_mem_wait();
        test_timeout();
        test_halt();
        test_halt_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
